// File: rtl/sqrt_error_monitor.sv
// sqrt_error_monitor
//   Characterises an approximate square-root datapath in hardware. Each
//   accepted (R, Q_approx) pair is run through an exact restoring
//   digit-by-digit square-root engine, and the error distance
//   ED = |floor(sqrt(R)) - Q_approx| is folded into saturating metrics.
//   The host derives ER, MED and NMED from these metrics.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   clear               sync clear of all metrics; drops any in-flight sample
//   in_valid/in_ready   sample handshake, accept on in_valid & in_ready
//   in_r, in_q          radicand and approximate root under test
//   done                one-cycle pulse, metric outputs updated this cycle
//   ref_q, last_ed      exact root and ED of the last completed sample
//   sample_cnt, err_cnt completed samples / samples with ED != 0 (saturating)
//   ed_sum, ed_max      sum of ED (saturating) / largest ED seen
module sqrt_error_monitor #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8,
   parameter int CNT_W = 17,
   parameter int SUM_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_r,
   input  logic [OUT_W-1:0] in_q,
   output logic             done,
   output logic [OUT_W-1:0] ref_q,
   output logic [OUT_W-1:0] last_ed,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [SUM_W-1:0] ed_sum,
   output logic [OUT_W-1:0] ed_max
);

   // Partial remainder after a shift-in needs OUT_W+2 bits on the last step.
   localparam int REM_W = OUT_W + 2;
   localparam int IT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   // Accumulator headroom: wide enough to hold either operand plus a carry,
   // so saturation works even when SUM_W < OUT_W.
   localparam int ACC_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
   localparam logic [SUM_W-1:0] SUM_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, CALC, UPD} state_t;

   state_t           state;
   logic [IN_W-1:0]  r_sh;    // radicand, consumed two bits per cycle MSB first
   logic [OUT_W-1:0] q_lat;   // approximate root under test
   logic [OUT_W-1:0] rem;     // partial remainder (bounded by 2*root < 2^OUT_W mid-run)
   logic [OUT_W-1:0] root;    // partial exact root
   logic [IT_W-1:0]  it;      // iterations remaining minus one

   logic [REM_W-1:0] rem_sh;
   logic [REM_W-1:0] trial;
   logic [REM_W-1:0] diff;
   logic             ge;
   logic [OUT_W-1:0] ed;
   logic [ACC_W-1:0] sum_ext;
   logic             sum_sat;

   // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
   always_comb begin
      rem_sh = {rem, r_sh[IN_W-1 -: 2]};
      trial  = {root, 2'b01};
      diff   = rem_sh - trial;
      ge     = (rem_sh >= trial);
   end

   // Error distance and saturating sum for the UPD cycle.
   always_comb begin
      ed      = (root >= q_lat) ? (root - q_lat) : (q_lat - root);
      sum_ext = ACC_W'(ed_sum) + ACC_W'(ed);
      sum_sat = (sum_ext > ACC_W'(SUM_MAX));
   end

   assign in_ready = (state == IDLE) & ~clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         r_sh       <= '0;
         q_lat      <= '0;
         rem        <= '0;
         root       <= '0;
         it         <= '0;
         done       <= 1'b0;
         ref_q      <= '0;
         last_ed    <= '0;
         sample_cnt <= '0;
         err_cnt    <= '0;
         ed_sum     <= '0;
         ed_max     <= '0;
      end else if (clear) begin
         state      <= IDLE;
         done       <= 1'b0;
         ref_q      <= '0;
         last_ed    <= '0;
         sample_cnt <= '0;
         err_cnt    <= '0;
         ed_sum     <= '0;
         ed_max     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // clear is known low here, so in_ready == 1
               if (in_valid) begin
                  r_sh  <= in_r;
                  q_lat <= in_q;
                  rem   <= '0;
                  root  <= '0;
                  it    <= IT_W'(OUT_W - 1);
                  state <= CALC;
               end
            end
            CALC: begin
               // Final-step remainder can exceed OUT_W bits but is never used.
               rem  <= OUT_W'(ge ? diff : rem_sh);
               root <= {root[OUT_W-2:0], ge};
               r_sh <= {r_sh[IN_W-3:0], 2'b00};
               if (it == '0) state <= UPD;
               else          it    <= it - IT_W'(1);
            end
            UPD: begin
               ref_q   <= root;
               last_ed <= ed;
               if (sample_cnt != CNT_MAX)
                  sample_cnt <= sample_cnt + CNT_W'(1);
               if (ed != '0 && err_cnt != CNT_MAX)
                  err_cnt <= err_cnt + CNT_W'(1);
               ed_sum  <= sum_sat ? SUM_MAX : sum_ext[SUM_W-1:0];
               if (ed > ed_max)
                  ed_max <= ed;
               done    <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
